if_fetch: RTL and testbench

- Instruction-fetch stage. Owns the PC and issues word fetches to the memory controller.
- Presents each fetched instruction to the IF/ID pipeline register as a one-cycle valid pulse (instE_out, pc_out, inst_out).
- Obeys pipeline stall and jump/branch redirect. Sits between the PC-redirect source (EX) and the memory controller on one side, and IF/ID on the other.

---
 rtl/if_fetch_pkg.sv | 5 +
 rtl/if_fetch_if.sv | 9 +
 rtl/if_fetch_icache.sv | 41 ++++
 rtl/if_fetch.sv | 98 +++++++++
 tb/tb_if_fetch.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared FSM state encoding and constants for the instruction-fetch stage.
package if_fetch_pkg;
  typedef enum logic [1:0] {IF_IDLE, IF_WAIT, IF_HOLD} if_state_e;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: fetch-to-memory-controller request/response bus.
interface if_fetch_if #(parameter int ADDR_W = 32, parameter int INST_W = 32);
  logic              memReq_out;
  logic [ADDR_W-1:0] memAddr_out;
  logic              memDone_in;
  logic [INST_W-1:0] memData_in;
  modport master(output memReq_out, memAddr_out, input memDone_in, memData_in);
  modport slave(input memReq_out, memAddr_out, output memDone_in, memData_in);
endinterface

// File: rtl/if_fetch_icache.sv
// if_icache: direct-mapped instruction cache with a combinational lookup port and a fill port.
module if_icache #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [INST_W-1:0] word_o,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [INST_W-1:0] fill_word_i
);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int N = 2 ** IDX_W;
  logic [N-1:0]      valid_q;
  logic [TAG_W-1:0]  tag_q [N];
  logic [INST_W-1:0] data_q [N];
  logic [IDX_W-1:0]  l_idx, f_idx;
  logic [TAG_W-1:0]  l_tag, f_tag;
  assign l_idx = lookup_addr_i[IDX_W+1:2];
  assign l_tag = lookup_addr_i[ADDR_W-1:IDX_W+2];
  assign f_idx = fill_addr_i[IDX_W+1:2];
  assign f_tag = fill_addr_i[ADDR_W-1:IDX_W+2];
  assign hit_o = valid_q[l_idx] && tag_q[l_idx] == l_tag;
  assign word_o = data_q[l_idx];
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else if (fill_i) valid_q[f_idx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[f_idx] <= f_tag;
      data_q[f_idx] <= fill_word_i;
    end
  end
  logic unused_ok;
  assign unused_ok = ^{lookup_addr_i[1:0], fill_addr_i[1:0]};
endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage owning the PC, issuing word fetches and presenting one-cycle instruction pulses.
// Optional direct-mapped icache enabled by defining IF_ICACHE_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter int              INST_W       = 32,
  parameter int              STALL_W      = 6,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int              ICACHE_IDX_W = 6
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [STALL_W-1:0] stall_in,
  input  logic               pcJump_in,
  input  logic [ADDR_W-1:0]  pcTarget_in,
  if_fetch_if.master         mem,
  output logic               instE_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INST_W-1:0]  inst_out,
  output logic               ifBusy_out
);
  if_state_e         state_q;
  logic [ADDR_W-1:0] pc_q, addr_q, pc_out_q, target;
  logic [INST_W-1:0] hold_q, inst_out_q, cache_word;
  logic              kill_q, req_q, inst_e_q, cache_hit, stall;
  assign stall = stall_in[0];
  assign target = {pcTarget_in[ADDR_W-1:2], 2'b00};
  assign mem.memReq_out = req_q;
  assign mem.memAddr_out = addr_q;
  assign instE_out = inst_e_q;
  assign pc_out = pc_out_q;
  assign inst_out = inst_out_q;
  assign ifBusy_out = state_q == IF_WAIT;
`ifdef IF_ICACHE_EN
  if_icache #(.ADDR_W(ADDR_W), .INST_W(INST_W), .IDX_W(ICACHE_IDX_W)) u_icache (
    .clk(clk_in),
    .rst(rst_in),
    .lookup_addr_i(pc_q),
    .hit_o(cache_hit),
    .word_o(cache_word),
    .fill_i(state_q == IF_WAIT && mem.memDone_in),
    .fill_addr_i(addr_q),
    .fill_word_i(mem.memData_in)
  );
`else
  assign cache_hit = 1'b0;
  assign cache_word = '0;
  logic unused_cfg;
  assign unused_cfg = ^ICACHE_IDX_W;
`endif
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IF_IDLE;
      pc_q <= RESET_PC;
      kill_q <= 1'b0;
      req_q <= 1'b0;
      addr_q <= '0;
      hold_q <= '0;
      inst_e_q <= 1'b0;
      pc_out_q <= '0;
      inst_out_q <= '0;
    end else begin
      inst_e_q <= 1'b0;
      if (pcJump_in) pc_q <= target;
      case (state_q)
        IF_IDLE: if (!pcJump_in && !stall) begin
          if (cache_hit) begin
            hold_q <= cache_word;
            state_q <= IF_HOLD;
          end else begin
            req_q <= 1'b1;
            addr_q <= pc_q;
            state_q <= IF_WAIT;
          end
        end
        // an outstanding request is never withdrawn; a redirect only marks its data for discard
        IF_WAIT: if (mem.memDone_in) begin
          req_q <= 1'b0;
          kill_q <= 1'b0;
          hold_q <= (kill_q || pcJump_in) ? hold_q : mem.memData_in;
          state_q <= (kill_q || pcJump_in) ? IF_IDLE : IF_HOLD;
        end else if (pcJump_in) kill_q <= 1'b1;
        IF_HOLD: if (pcJump_in) state_q <= IF_IDLE;
        else if (!stall) begin
          inst_e_q <= 1'b1;
          pc_out_q <= pc_q;
          inst_out_q <= hold_q;
          pc_q <= pc_q + ADDR_W'(PC_STEP);
          state_q <= IF_IDLE;
        end
        default: state_q <= IF_IDLE;
      endcase
    end
  end
  logic unused_ok;
  assign unused_ok = ^{stall_in[STALL_W-1:1], pcTarget_in[1:0]};
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed vector table, corner sequences and a randomized run against a transaction-level PC model.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst, jump, ie, busy;
  logic [5:0]  stall;
  logic [31:0] tgt, pc_o, inst_o;
  int checks = 0;
  int errors = 0;
  if_fetch_if #(.ADDR_W(32), .INST_W(32)) mem_if ();
  if_fetch dut (
    .clk_in(clk), .rst_in(rst), .stall_in(stall), .pcJump_in(jump), .pcTarget_in(tgt),
    .mem(mem_if), .instE_out(ie), .pc_out(pc_o), .inst_out(inst_o), .ifBusy_out(busy)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic [5:0] stall; logic jump; logic [31:0] tgt; logic done; logic [31:0] data;
    logic req; logic [31:0] addr; logic ie; logic [31:0] pc; logic [31:0] inst; logic busy;
  } vec_t;

  function automatic vec_t mk(logic r, logic [5:0] s, logic j, logic [31:0] t, logic d, logic [31:0] dat,
                              logic rq, logic [31:0] a, logic e, logic [31:0] p, logic [31:0] in, logic b);
    vec_t v;
    v = '{rst: r, stall: s, jump: j, tgt: t, done: d, data: dat, req: rq, addr: a, ie: e, pc: p, inst: in, busy: b};
    return v;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] s, input logic j, input logic [31:0] t,
                      input logic d, input logic [31:0] dat);
    rst = r; stall = s; jump = j; tgt = t;
    mem_if.memDone_in = d; mem_if.memData_in = dat;
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vec [34];
  logic [31:0] mpc, maddr, pa, t;
  logic mbusy, pr, pie, s, j, d;
  logic [31:0] dat;
  int cnt, n;

  initial begin
    vec[0]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 1);
    vec[1]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 1);
    vec[2]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 1);
    vec[3]  = mk(0, 0, 0, 0, 1, 32'h13, 0, 0, 0, 0, 0, 0);
    vec[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h13, 0);
    vec[5]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h4, 0, 0, 0, 1);
    vec[6]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h4, 0, 0, 0, 1);
    vec[7]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h4, 0, 0, 0, 1);
    vec[8]  = mk(0, 0, 0, 0, 1, 32'h13, 0, 0, 0, 0, 0, 0);
    for (int i = 9; i < 14; i++) vec[i] = mk(0, 6'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4, 32'h13, 0);
    vec[15] = mk(0, 6'h3E, 0, 0, 0, 0, 1, 32'h8, 0, 0, 0, 1);
    vec[16] = mk(0, 0, 1, 32'h100, 0, 0, 1, 32'h8, 0, 0, 0, 1);
    vec[17] = mk(0, 0, 0, 0, 0, 0, 1, 32'h8, 0, 0, 0, 1);
    vec[18] = mk(0, 0, 0, 0, 1, 32'hDEAD, 0, 0, 0, 0, 0, 0);
    vec[19] = mk(0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 1);
    vec[20] = mk(0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 1);
    vec[21] = mk(0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 1);
    vec[22] = mk(0, 0, 1, 32'h203, 1, 32'hBEEF, 0, 0, 0, 0, 0, 0);
    vec[23] = mk(0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0, 0, 1);
    vec[24] = mk(0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0, 0, 1);
    vec[25] = mk(0, 0, 0, 0, 1, 32'h13, 0, 0, 0, 0, 0, 0);
    vec[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 32'h13, 0);
    vec[27] = mk(0, 0, 0, 0, 0, 0, 1, 32'h204, 0, 0, 0, 1);
    vec[28] = mk(1, 6'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[29] = mk(0, 6'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[30] = mk(0, 6'h01, 0, 0, 1, 32'h99, 0, 0, 0, 0, 0, 0);
    vec[31] = mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 1);
    vec[32] = mk(0, 0, 0, 0, 1, 32'h77, 0, 0, 0, 0, 0, 0);
    vec[33] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h77, 0);

    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_req", {31'b0, mem_if.memReq_out}, 0);
    chk("rst_addr", mem_if.memAddr_out, 0);
    chk("rst_ie", {31'b0, ie}, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_busy", {31'b0, busy}, 0);

    for (int i = 0; i < 34; i++) begin
      step(vec[i].rst, vec[i].stall, vec[i].jump, vec[i].tgt, vec[i].done, vec[i].data);
      chk($sformatf("v%0d_req", i), {31'b0, mem_if.memReq_out}, {31'b0, vec[i].req});
      chk($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, vec[i].busy});
      chk($sformatf("v%0d_ie", i), {31'b0, ie}, {31'b0, vec[i].ie});
      if (vec[i].req) chk($sformatf("v%0d_addr", i), mem_if.memAddr_out, vec[i].addr);
      if (vec[i].ie) begin
        chk($sformatf("v%0d_pc", i), pc_o, vec[i].pc);
        chk($sformatf("v%0d_inst", i), inst_o, vec[i].inst);
      end
    end

    // second redirect while a killed fetch is outstanding wins
    step(0, 0, 0, 0, 0, 0);
    chk("dj_addr", mem_if.memAddr_out, 32'h4);
    step(0, 0, 1, 32'h300, 0, 0);
    step(0, 0, 1, 32'h401, 0, 0);
    chk("dj_hold", mem_if.memAddr_out, 32'h4);
    step(0, 0, 0, 0, 1, 32'h1);
    chk("dj_drop", {31'b0, mem_if.memReq_out}, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("dj_addr2", mem_if.memAddr_out, 32'h400);
    step(0, 0, 0, 0, 1, 32'h55);
    step(0, 0, 0, 0, 0, 0);
    chk("dj_ie", {31'b0, ie}, 1);
    chk("dj_pc", pc_o, 32'h400);
    chk("dj_inst", inst_o, 32'h55);

`ifdef IF_ICACHE_EN
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h11);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("c_addr4", mem_if.memAddr_out, 32'h4);
    step(0, 0, 0, 0, 1, 32'h22);
    step(0, 0, 0, 0, 0, 0);
    chk("c_pc4", pc_o, 32'h4);
    step(0, 0, 1, 32'h0, 0, 0);
    chk("c_nojreq", {31'b0, mem_if.memReq_out}, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("c_hitreq", {31'b0, mem_if.memReq_out}, 0);
    chk("c_hitbusy", {31'b0, busy}, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("c_ie", {31'b0, ie}, 1);
    chk("c_pc", pc_o, 32'h0);
    chk("c_inst", inst_o, 32'h11);
`endif

    // randomized run: request addresses and presented PCs follow the architectural PC
    step(1, 0, 0, 0, 0, 0);
    mpc = 0; mbusy = 0; pr = 0; pie = 0; pa = 0; n = 0; cnt = 0; maddr = 0;
    for (int c = 0; c < 3000; c++) begin
      d = 0; dat = 0;
      if (mbusy) begin
        if (cnt == 0) begin
          d = 1; dat = mem_word(maddr); mbusy = 0;
        end else cnt--;
      end else if (mem_if.memReq_out) begin
        mbusy = 1; maddr = mem_if.memAddr_out; cnt = $urandom_range(0, 3);
      end
      s = $urandom_range(0, 3) == 0;
      j = $urandom_range(0, 19) == 0;
      t = $urandom;
      if (j) mpc = {t[31:2], 2'b00};
      step(0, {5'($urandom), s}, j, t, d, dat);
      if (mem_if.memReq_out && !pr) chk("rnd_req_addr", mem_if.memAddr_out, mpc);
      else if (mem_if.memReq_out) chk("rnd_addr_hold", mem_if.memAddr_out, pa);
      if (ie) begin
        chk("rnd_pc", pc_o, mpc);
        chk("rnd_inst", inst_o, mem_word(mpc));
        chk("rnd_ie_gate", {29'b0, pie, s, j}, 0);
        mpc = mpc + 4;
        n++;
      end
      pr = mem_if.memReq_out; pa = mem_if.memAddr_out; pie = ie;
    end
    chk("rnd_progress", {31'b0, n > 100}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
